// File: rtl/hazard_sequencer_if.sv
// Decode-side handshake bundle between the MIPS8 pipeline front end and the
// hazard sequencer: decode fields and memory/jump status in, pipeline
// enables, flushes and debug counters out.
interface hazard_sequencer_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) ();
    logic             id_valid;
    logic [4:0]       id_opcode;
    logic [REG_W-1:0] id_rd;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             ex_jump_taken;
    logic             mem_busy;

    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    // Pipeline side: drives decode state, observes control
    modport master (
        output id_valid, id_opcode, id_rd, id_rs, id_rt, ex_jump_taken, mem_busy,
        input  pc_en, if_id_en, if_id_flush, id_ex_flush, stall_cycles, flush_events
    );

    // Sequencer side
    modport slave (
        input  id_valid, id_opcode, id_rd, id_rs, id_rt, ex_jump_taken, mem_busy,
        output pc_en, if_id_en, if_id_flush, id_ex_flush, stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard and flow controller for the MIPS8 five-stage core. Keeps a private
// copy of EX/MEM occupancy and derives PC / IF/ID / ID/EX enables and flushes
// for load-use stalls, flags stalls, taken-jump flushes and memory freezes.
module hazard_sequencer #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_sequencer_if.slave  bus
);
    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_MOV  = 5'd6;
    localparam logic [4:0] OP_LW   = 5'd7;
    localparam logic [4:0] OP_SW   = 5'd8;
    localparam logic [4:0] OP_LI   = 5'd9;
    localparam logic [4:0] OP_ADDI = 5'd10;
    localparam logic [4:0] OP_SUBI = 5'd11;
    localparam logic [4:0] OP_CMP  = 5'd12;
    localparam logic [4:0] OP_JZ   = 5'd13;
    localparam logic [4:0] OP_JNZ  = 5'd14;
    localparam logic [4:0] OP_JG   = 5'd15;
    localparam logic [4:0] OP_JL   = 5'd16;
    localparam logic [4:0] OP_JUMP = 5'd17;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Decode-stage classification
    logic id_writes_reg, id_writes_flags, id_reads_rs, id_reads_rt;
    logic id_is_load, id_is_jump, id_is_cond_jump;

    // EX and MEM slot state
    logic             ex_valid, mem_valid;
    logic [REG_W-1:0] ex_dest, mem_dest;
    logic             ex_is_load, ex_writes_reg, ex_writes_flags, ex_is_jump;
    logic             mem_is_load, mem_writes_reg, mem_writes_flags, mem_is_jump;

    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic load_use, flags_haz, hazard, take_flush, freeze, advance;

    // MEM slot contents are tracked for completeness but only forwarding
    // (outside this block) consumes them.
    logic unused_mem;
    assign unused_mem = ^{mem_valid, mem_dest, mem_is_load, mem_writes_reg,
                          mem_writes_flags, mem_is_jump};

    // Opcode class decode; undefined opcodes fall through as NOP
    always_comb begin
        id_writes_reg   = 1'b0;
        id_writes_flags = 1'b0;
        id_reads_rs     = 1'b0;
        id_reads_rt     = 1'b0;
        id_is_load      = 1'b0;
        id_is_jump      = 1'b0;
        id_is_cond_jump = 1'b0;
        case (bus.id_opcode)
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_CMP: begin
                id_writes_reg   = 1'b1;
                id_writes_flags = 1'b1;
                id_reads_rs     = 1'b1;
                id_reads_rt     = 1'b1;
            end
            OP_MOV: begin
                id_writes_reg = 1'b1;
                id_reads_rs   = 1'b1;
            end
            OP_LW: begin
                id_writes_reg = 1'b1;
                id_reads_rs   = 1'b1;
                id_is_load    = 1'b1;
            end
            OP_SW: begin
                id_reads_rs = 1'b1;
                id_reads_rt = 1'b1;
            end
            OP_LI: id_writes_reg = 1'b1;
            OP_ADDI, OP_SUBI: begin
                id_writes_reg   = 1'b1;
                id_writes_flags = 1'b1;
                id_reads_rs     = 1'b1;
            end
            OP_JZ, OP_JNZ, OP_JG, OP_JL: begin
                id_is_jump      = 1'b1;
                id_is_cond_jump = 1'b1;
            end
            OP_JUMP: id_is_jump = 1'b1;
            OP_NOP:  ;
            default: ;
        endcase
    end

    // Hazard detection; only a load in EX cannot be forwarded in time
    always_comb begin
        load_use   = ex_valid & ex_is_load &
                     ((id_reads_rs & (bus.id_rs == ex_dest)) |
                      (id_reads_rt & (bus.id_rt == ex_dest)));
        flags_haz  = id_is_cond_jump & ex_valid & ex_writes_flags;
        hazard     = bus.id_valid & (load_use | flags_haz);
        take_flush = ex_valid & ex_is_jump & bus.ex_jump_taken;
        freeze     = bus.mem_busy;
        advance    = ~take_flush & ~hazard;
    end

    // Pipeline control outputs, priority freeze > flush > stall > advance
    always_comb begin
        bus.pc_en       = 1'b1;
        bus.if_id_en    = 1'b1;
        bus.if_id_flush = 1'b0;
        bus.id_ex_flush = 1'b0;
        if (rst) begin
            bus.pc_en       = 1'b0;
            bus.if_id_en    = 1'b0;
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (freeze) begin
            bus.pc_en    = 1'b0;
            bus.if_id_en = 1'b0;
        end else if (take_flush) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (hazard) begin
            bus.pc_en       = 1'b0;
            bus.if_id_en    = 1'b0;
            bus.id_ex_flush = 1'b1;
        end
    end

    // Slot occupancy and event counters; everything holds during a freeze
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!freeze) begin
            mem_valid <= ex_valid;
            ex_valid  <= advance ? bus.id_valid : 1'b0;
            if (take_flush)
                flush_cnt <= sat_inc(flush_cnt);
            else if (hazard)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

    // Slot payload; meaningless while the matching valid bit is low
    always_ff @(posedge clk) begin
        if (!freeze) begin
            mem_dest         <= ex_dest;
            mem_is_load      <= ex_is_load;
            mem_writes_reg   <= ex_writes_reg;
            mem_writes_flags <= ex_writes_flags;
            mem_is_jump      <= ex_is_jump;
            if (advance) begin
                ex_dest         <= bus.id_rd;
                ex_is_load      <= id_is_load;
                ex_writes_reg   <= id_writes_reg;
                ex_writes_flags <= id_writes_flags;
                ex_is_jump      <= id_is_jump;
            end
        end
    end

    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_events = flush_cnt;
endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: load-use, flags, taken jumps, freeze
// priority, reset behaviour and counter saturation (narrow second instance).
module tb_hazard_sequencer;
    localparam logic [4:0] NOP = 5'd0,  ADD = 5'd1,  LW = 5'd7,  SW = 5'd8;
    localparam logic [4:0] LI  = 5'd9,  CMP = 5'd12, JZ = 5'd13, JNZ = 5'd14;
    localparam logic [4:0] JUMP = 5'd17;
    localparam logic [4:0] UNDEF = 5'd20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    hazard_sequencer_if #(.REG_W(3), .CNT_W(16)) bus ();
    hazard_sequencer_if #(.REG_W(3), .CNT_W(5))  sat_bus ();

    hazard_sequencer #(.REG_W(3), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    hazard_sequencer #(.REG_W(3), .CNT_W(5))  dut_sat (.clk(clk), .rst(rst), .bus(sat_bus));

    assign sat_bus.id_valid      = bus.id_valid;
    assign sat_bus.id_opcode     = bus.id_opcode;
    assign sat_bus.id_rd         = bus.id_rd;
    assign sat_bus.id_rs         = bus.id_rs;
    assign sat_bus.id_rt         = bus.id_rt;
    assign sat_bus.ex_jump_taken = bus.ex_jump_taken;
    assign sat_bus.mem_busy      = bus.mem_busy;

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Control vector is {pc_en, if_id_en, if_id_flush, id_ex_flush}
    task automatic check_ctl(input string tag, input logic [3:0] exp);
        check_eq(tag, {28'd0, bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush}, {28'd0, exp});
    endtask

    task automatic check_cnt(input string tag, input int stalls, input int flushes);
        check_eq({tag, "_stall"}, {16'd0, bus.stall_cycles}, stalls);
        check_eq({tag, "_flush"}, {16'd0, bus.flush_events}, flushes);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] rd,
                         input logic [2:0] rs, input logic [2:0] rt);
        bus.id_valid  = v;
        bus.id_opcode = op;
        bus.id_rd     = rd;
        bus.id_rs     = rs;
        bus.id_rt     = rt;
        #1;
    endtask

    initial begin
        bus.ex_jump_taken = 1'b0;
        bus.mem_busy      = 1'b0;
        drive(1'b1, NOP, 3'd0, 3'd0, 3'd0);

        // Reset held for three cycles
        repeat (3) tick;
        check_ctl("rst_ctl", 4'b0011);
        check_cnt("rst", 0, 0);
        rst = 1'b0;
        #1;
        check_ctl("rel_ctl", 4'b1100);
        check_cnt("rel", 0, 0);
        tick;

        // Load-use via rs
        drive(1'b1, LW, 3'd2, 3'd1, 3'd0);   check_ctl("lw_adv", 4'b1100); tick;
        drive(1'b1, ADD, 3'd3, 3'd2, 3'd1);  check_ctl("lu_rs_stall", 4'b0001); tick;
        check_ctl("lu_rs_go", 4'b1100);      check_cnt("lu_rs", 1, 0); tick;
        // Load-use via rt
        drive(1'b1, LW, 3'd4, 3'd0, 3'd0);   check_ctl("lw2_adv", 4'b1100); tick;
        drive(1'b1, SW, 3'd0, 3'd5, 3'd4);   check_ctl("lu_rt_stall", 4'b0001); tick;
        check_ctl("lu_rt_go", 4'b1100);      check_cnt("lu_rt", 2, 0); tick;
        // LI reads nothing, undefined opcode reads nothing
        drive(1'b1, LW, 3'd6, 3'd0, 3'd0);   tick;
        drive(1'b1, LI, 3'd6, 3'd6, 3'd6);   check_ctl("li_nostall", 4'b1100); tick;
        drive(1'b1, LW, 3'd3, 3'd0, 3'd0);   tick;
        drive(1'b1, UNDEF, 3'd0, 3'd3, 3'd3); check_ctl("undef_nostall", 4'b1100); tick;

        // Flags dependency
        drive(1'b1, CMP, 3'd0, 3'd1, 3'd2);  check_ctl("cmp_adv", 4'b1100); tick;
        drive(1'b1, JZ, 3'd0, 3'd0, 3'd0);   check_ctl("flag_stall", 4'b0001); tick;
        check_ctl("flag_go", 4'b1100);       check_cnt("flag", 3, 0); tick;
        drive(1'b1, CMP, 3'd0, 3'd1, 3'd2);  check_ctl("jz_not_taken", 4'b1100); tick;
        drive(1'b1, NOP, 3'd0, 3'd0, 3'd0);  tick;
        drive(1'b1, JNZ, 3'd0, 3'd0, 3'd0);  check_ctl("flag_gap", 4'b1100); tick;
        check_cnt("flag_gap", 3, 0);

        // Taken jump
        drive(1'b1, JUMP, 3'd0, 3'd0, 3'd0); check_ctl("jnz_not_taken", 4'b1100); tick;
        bus.ex_jump_taken = 1'b1;
        drive(1'b1, ADD, 3'd1, 3'd1, 3'd1);  check_ctl("jmp_flush", 4'b1111);
        check_cnt("jmp_pre", 3, 0); tick;
        drive(1'b1, LW, 3'd2, 3'd0, 3'd0);   check_ctl("taken_no_jump_in_ex", 4'b1100);
        check_cnt("jmp_post", 3, 1);
        bus.ex_jump_taken = 1'b0;
        tick;

        // Freeze over a load-use hazard
        bus.mem_busy = 1'b1;
        drive(1'b1, ADD, 3'd3, 3'd2, 3'd0);  check_ctl("frz_lu", 4'b0000); tick;
        check_ctl("frz_lu_hold", 4'b0000);   check_cnt("frz_lu", 3, 1); tick;
        bus.mem_busy = 1'b0;
        #1;
        check_ctl("frz_lu_release", 4'b0001); tick;
        check_ctl("frz_lu_go", 4'b1100);     check_cnt("frz_lu_go", 4, 1); tick;

        // Freeze over a taken jump, then flush on release
        drive(1'b1, JUMP, 3'd0, 3'd0, 3'd0); tick;
        bus.mem_busy      = 1'b1;
        bus.ex_jump_taken = 1'b1;
        drive(1'b1, JZ, 3'd0, 3'd0, 3'd0);   check_ctl("frz_jmp", 4'b0000); tick;
        check_ctl("frz_jmp_hold", 4'b0000);  check_cnt("frz_jmp", 4, 1); tick;
        bus.mem_busy = 1'b0;
        #1;
        check_ctl("frz_jmp_release", 4'b1111); tick;
        bus.ex_jump_taken = 1'b0;
        drive(1'b1, NOP, 3'd0, 3'd0, 3'd0);  check_ctl("frz_jmp_after", 4'b1100);
        check_cnt("frz_jmp_after", 4, 2); tick;

        // Reset mid-stall leaves no pending stall
        drive(1'b1, LW, 3'd2, 3'd0, 3'd0);   tick;
        drive(1'b1, ADD, 3'd3, 3'd2, 3'd0);  check_ctl("pre_rst_stall", 4'b0001);
        #2 rst = 1'b1;
        #1;
        check_ctl("midrst_ctl", 4'b0011);    check_cnt("midrst", 0, 0);
        tick;
        rst = 1'b0;
        #1;
        check_ctl("midrst_release", 4'b1100); tick;

        // Chained dependent loads: one stall per pair; narrow counter saturates
        drive(1'b1, LW, 3'd2, 3'd2, 3'd0);
        repeat (80) tick;
        check_eq("chain_stalls", {16'd0, bus.stall_cycles}, 32'd40);
        check_eq("sat_reach", {27'd0, sat_bus.stall_cycles}, 32'd31);
        repeat (10) tick;
        check_eq("chain_stalls_more", {16'd0, bus.stall_cycles}, 32'd45);
        check_eq("sat_hold", {27'd0, sat_bus.stall_cycles}, 32'd31);
        check_eq("sat_flush", {27'd0, sat_bus.flush_events}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard and flow controller for the MIPS8 five-stage core. It takes the instruction in decode and tracks its own copy of EX/MEM occupancy. From these it generates the per-cycle enables and flushes for the PC, IF/ID and ID/EX registers: load-use stalls, flags-dependency stalls for conditional jumps, flushes for taken jumps, and a whole-pipe freeze when memory is busy. It sits beside the decode-stage control unit and uses the same 5-bit opcode encoding. It also keeps saturating stall and flush event counters for debug.

## Interface
- REG_W, 3, register-address width (8 GPRs)
- CNT_W, 16, width of both event counters
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_opcode  in  5  decode opcode (NOP=0 … JUMP=17, ISA encoding)
- id_rd, id_rs, id_rt  in  REG_W each  decode register fields
- ex_jump_taken  in  1  jump currently in EX resolved taken (ignored unless EX slot holds JZ/JNZ/JG/JL/JUMP)
- mem_busy  in  1  data memory not ready; freeze entire pipe
- pc_en  out  1  PC may advance or load target
- if_id_en  out  1  IF/ID register may load
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_flush  out  1  load bubble into ID/EX
- stall_cycles  out  CNT_W  count of hazard-stall cycles
- flush_events  out  CNT_W  count of taken-jump flushes

## Operation
- Internal slots EX and MEM each hold valid, dest, is_load, writes_reg, writes_flags, is_jump.
- Decode classes:
  - Writes reg: ADD, SUB, OR, AND, XOR, MOV, LW, LI, ADDI, SUBI, CMP.
  - Writes flags: ADD…XOR, ADDI, SUBI, CMP.
  - Reads rs: ALU ops, CMP, MOV, LW, SW, ADDI, SUBI.
  - Reads rt: ALU ops, CMP, SW.
  - NOP, LI and jumps read nothing.
  - Undefined opcodes (18–31) behave as NOP.
- Load-use hazard: EX.valid & EX.is_load & ID reads a register equal to EX.dest. Forwarding from MEM covers all other RAW cases.
- Flags hazard: ID is JZ/JNZ/JG/JL & EX.valid & EX.writes_flags.
- hazard = id_valid & (load-use | flags).
- Priority per cycle: freeze > flush > stall > advance.
- Freeze (mem_busy=1):
  - pc_en=0, if_id_en=0, both flushes 0.
  - Slots hold; counters hold.
  - Any ex_jump_taken is deferred and must remain asserted by EX.
- Flush (EX.is_jump & ex_jump_taken, no freeze):
  - pc_en=1, if_id_en=1, if_id_flush=1, id_ex_flush=1.
  - Next EX slot becomes a bubble, and MEM takes the jump.
  - flush_events increments.
  - Any concurrent hazard is suppressed.
- Stall (hazard, no freeze/flush):
  - pc_en=0, if_id_en=0, id_ex_flush=1, if_id_flush=0.
  - Next EX slot becomes a bubble; MEM takes the old EX.
  - stall_cycles increments.
- Advance:
  - pc_en=1, if_id_en=1, both flushes 0.
  - EX takes the decoded ID instruction, with valid = id_valid; MEM takes the old EX.
- Counters saturate at all-ones and never wrap.

## Timing
- Enables and flushes are combinational from current inputs plus slot state, with zero-cycle latency. Slots and counters update on the rising clk edge.
- Load-use produces exactly 1 stall cycle; after it, the LW is in MEM and is forwarded.
- Flags hazard produces exactly 1 stall cycle.
- A taken jump costs 2 bubbles: the IF and ID instructions are squashed.
- While rst=1:
  - Slots are invalid and counters are 0.
  - pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1.
- First cycle after release, with empty slots, gives advance behaviour.
- Reset asserted mid-stall or mid-freeze clears all state immediately; there is no pending stall after release.
- A stall on LW→LW chains also gives 1 cycle per dependent pair; back-to-back hazards each count.

## Test plan
- **Reset:** hold rst 3 cycles, then release with NOP in ID → during reset the enables are 0 and flushes 1; after release pc_en=1, if_id_en=1, counters 0.
- **Load-use:** LW r2 then ADD r3,r2,r1 → exactly one cycle with pc_en=0, id_ex_flush=1; ADD advances next cycle; stall_cycles=1.
- **Flags:** CMP r1,r2 then JZ → one stall cycle. Repeat with NOP between CMP and JZ → no stall.
- **Taken jump:** JUMP reaches EX, ex_jump_taken=1 → if_id_flush=id_ex_flush=1 for 1 cycle; flush_events=1. With ex_jump_taken=0 → no flush.
- **Priority:** mem_busy=1 during a load-use hazard and a taken jump → full freeze, counters unchanged. When mem_busy drops with the jump still taken → flush, not stall.
- **Saturation:** force 65540 stall cycles → stall_cycles=0xFFFF and holds.
